hazard_sequencer: RTL and testbench

- Pipeline control block for the 5-stage RV32IC core. Sits beside the operand-forwarding logic and owns every case forwarding cannot resolve:
  - load-use stalls;
  - taken-branch flushes;
  - arbitration of the single-ported unified memory between instruction fetch (IF) and data access (MEM stage), including multi-cycle data accesses.
- Drives the enable, flush and hold controls of the PC and pipeline registers, plus the memory port select.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_sequencer_if.sv | 29 ++
 rtl/hazard_perf_counters.sv | 46 ++++
 rtl/hazard_sequencer.sv | 119 +++++++++++
 tb/tb_hazard_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard sequencer.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ACC_CNT_W  = 4;

    typedef enum logic {
        RUN  = 1'b0,
        DMEM = 1'b1
    } state_e;

    localparam logic MEM_SEL_FETCH = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;

    // True when the ID instruction reads the register a load in EX is about to write.
    function automatic logic load_use_hit(
        input logic                  memread,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return memread && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Pipeline-status inputs and pipeline-control outputs of the hazard sequencer.
// master = pipeline datapath side, slave = hazard sequencer.
interface hazard_sequencer_if;

    logic                             id_ex_memread;
    logic [hazard_pkg::REG_ADDR_W-1:0] id_ex_rd;
    logic [hazard_pkg::REG_ADDR_W-1:0] if_id_rs1;
    logic [hazard_pkg::REG_ADDR_W-1:0] if_id_rs2;
    logic                             ex_mem_memop;
    logic                             branch_taken;

    logic                             pc_stall;
    logic                             if_id_stall;
    logic                             if_id_flush;
    logic                             id_ex_flush;
    logic                             pipe_hold;
    logic                             mem_sel;

    modport master (
        output id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, ex_mem_memop, branch_taken,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, mem_sel
    );

    modport slave (
        input  id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2, ex_mem_memop, branch_taken,
        output pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, mem_sel
    );

endinterface

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters for stall/flush statistics (built only with HAZARD_PERF_EN).
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_inc,
    input  logic             dmem_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] dmem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [CNT_W-1:0] lu_q, lu_d;
    logic [CNT_W-1:0] dmem_q, dmem_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Increment on each event, sticking at all-ones instead of wrapping.
    always_comb begin
        lu_d    = lu_q;
        dmem_d  = dmem_q;
        flush_d = flush_q;
        if (lu_inc && (lu_q != '1))       lu_d    = lu_q + 1'b1;
        if (dmem_inc && (dmem_q != '1))   dmem_d  = dmem_q + 1'b1;
        if (flush_inc && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_q    <= '0;
            dmem_q  <= '0;
            flush_q <= '0;
        end else begin
            lu_q    <= lu_d;
            dmem_q  <= dmem_d;
            flush_q <= flush_d;
        end
    end

    assign lu_stall_cnt   = lu_q;
    assign dmem_stall_cnt = dmem_q;
    assign flush_cnt      = flush_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: load-use stalls, branch flushes and arbitration of the
// single-ported memory between fetch and multi-cycle data accesses.
// Define HAZARD_PERF_EN to add saturating stall/flush performance counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_sequencer_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  dmem_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    if (MEM_LAT < 1 || MEM_LAT > 15 || CNT_W < 1) begin : g_bad_param
        $error("hazard_sequencer: MEM_LAT must be 1..15 and CNT_W >= 1");
    end

    localparam logic [ACC_CNT_W-1:0] LAST_CNT = ACC_CNT_W'(MEM_LAT - 1);

    state_e               state_q, state_d;
    logic [ACC_CNT_W-1:0] cnt_q, cnt_d;
    logic                 load_use;
    logic                 access;
    logic                 last_cyc;

    // Next state and all control outputs, ordered by priority: access hold,
    // branch flush, load-use stall, end-of-access fetch bubble.
    // NOTE: every signal gets a default first so no path through the block leaves one unassigned (no latch).
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hz.pc_stall    = 1'b0;
        hz.if_id_stall = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.pipe_hold   = 1'b0;
        hz.mem_sel     = MEM_SEL_FETCH;

        load_use = load_use_hit(hz.id_ex_memread, hz.id_ex_rd, hz.if_id_rs1, hz.if_id_rs2);
        // Once in DMEM the MEM instruction is frozen, so the access continues regardless of memop.
        access   = (state_q == DMEM) || hz.ex_mem_memop;
        last_cyc = (cnt_q == LAST_CNT);

        if (access && !last_cyc) begin
            // Memory busy with data: freeze everything, EX results (incl. branches) wait.
            hz.mem_sel     = MEM_SEL_DATA;
            hz.pipe_hold   = 1'b1;
            hz.pc_stall    = 1'b1;
            hz.if_id_stall = 1'b1;
            state_d        = DMEM;
            cnt_d          = cnt_q + 1'b1;
        end else begin
            if (access) begin
                hz.mem_sel = MEM_SEL_DATA;
                state_d    = RUN;
                cnt_d      = '0;
            end
            if (hz.branch_taken) begin
                // PC update needs no memory, so the target loads even on a last access cycle.
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use) begin
                // The stall keeps the ID instruction, so it outranks the fetch bubble.
                hz.pc_stall    = 1'b1;
                hz.if_id_stall = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (access) begin
                // No fetch happened this cycle, so a NOP enters ID.
                hz.pc_stall    = 1'b1;
                hz.if_id_flush = 1'b1;
            end
        end

        if (rst) begin
            hz.pc_stall    = 1'b0;
            hz.if_id_stall = 1'b0;
            hz.if_id_flush = 1'b0;
            hz.id_ex_flush = 1'b0;
            hz.pipe_hold   = 1'b0;
            hz.mem_sel     = MEM_SEL_FETCH;
        end
    end

    // State and access-cycle counter; reset abandons any access in flight.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    // Event strobes are decoded from the output pattern each case uniquely produces.
    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .lu_inc         (hz.if_id_stall && hz.id_ex_flush),
        .dmem_inc       (hz.mem_sel && hz.pc_stall),
        .flush_inc      (hz.if_id_flush && hz.id_ex_flush),
        .lu_stall_cnt   (lu_stall_cnt),
        .dmem_stall_cnt (dmem_stall_cnt),
        .flush_cnt      (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: MEM_LAT=1 and MEM_LAT=3 instances driven
// with the same stimulus, directed scenarios plus randomized cycles against a model.
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       memread, memop, br;
    logic [4:0] rd, rs1, rs2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_sequencer_if if1 ();
    hazard_sequencer_if if3 ();

    assign if1.id_ex_memread = memread;
    assign if1.id_ex_rd      = rd;
    assign if1.if_id_rs1     = rs1;
    assign if1.if_id_rs2     = rs2;
    assign if1.ex_mem_memop  = memop;
    assign if1.branch_taken  = br;
    assign if3.id_ex_memread = memread;
    assign if3.id_ex_rd      = rd;
    assign if3.if_id_rs1     = rs1;
    assign if3.if_id_rs2     = rs2;
    assign if3.ex_mem_memop  = memop;
    assign if3.branch_taken  = br;

`ifdef HAZARD_PERF_EN
    logic [7:0] lu1, dm1, fl1, lu3, dm3, fl3;
    logic       sat_inc = 1'b0;
    logic [1:0] sat_lu, sat_dm, sat_fl;

    hazard_perf_counters #(.CNT_W(2)) u_sat (
        .clk (clk), .rst (rst), .lu_inc (sat_inc), .dmem_inc (sat_inc), .flush_inc (sat_inc),
        .lu_stall_cnt (sat_lu), .dmem_stall_cnt (sat_dm), .flush_cnt (sat_fl)
    );
`endif

    hazard_sequencer #(.MEM_LAT(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .hz  (if1)
`ifdef HAZARD_PERF_EN
        ,
        .lu_stall_cnt   (lu1),
        .dmem_stall_cnt (dm1),
        .flush_cnt      (fl1)
`endif
    );

    hazard_sequencer #(.MEM_LAT(3), .CNT_W(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .hz  (if3)
`ifdef HAZARD_PERF_EN
        ,
        .lu_stall_cnt   (lu3),
        .dmem_stall_cnt (dm3),
        .flush_cnt      (fl3)
`endif
    );

    // Observed outputs as {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_hold, mem_sel}.
    logic [5:0] o1, o3;
    assign o1 = {if1.pc_stall, if1.if_id_stall, if1.if_id_flush, if1.id_ex_flush, if1.pipe_hold, if1.mem_sel};
    assign o3 = {if3.pc_stall, if3.if_id_stall, if3.if_id_flush, if3.id_ex_flush, if3.pipe_hold, if3.mem_sel};

    // Reference model: "left" is the number of access cycles still owed (0 = no access).
    int left1 = 0;
    int left3 = 0;

    function automatic logic [5:0] model_out(input int lat, input int left);
        logic       in_acc, last, lu;
        int         to_go;
        logic [5:0] e;
        e      = '0;
        in_acc = (left > 0) || memop;
        to_go  = (left > 0) ? left : lat;
        last   = (to_go == 1);
        lu     = memread && (rd != 0) && ((rd == rs1) || (rd == rs2));
        if (rst) return 6'b000000;
        if (in_acc && !last) return 6'b110011;
        if (br)          e = 6'b001100;
        else if (lu)     e = 6'b110100;
        else if (in_acc) e = 6'b101000;
        if (in_acc) e[0] = 1'b1;
        return e;
    endfunction

    function automatic int model_next(input int lat, input int left);
        if (rst)      return 0;
        if (left > 0) return left - 1;
        if (memop)    return lat - 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        left1 <= model_next(1, left1);
        left3 <= model_next(3, left3);
    end

    task automatic idle();
        rst = 1'b0; memread = 1'b0; memop = 1'b0; br = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0; memop = 1'b1; br = 1'b1;
        @(negedge clk);
        n_total++; if (o1 !== 6'b000000) $display("FAIL reset_lat1: got %b expected %b", o1, 6'b000000); else n_pass++;
        n_total++; if (o3 !== 6'b000000) $display("FAIL reset_lat3: got %b expected %b", o3, 6'b000000); else n_pass++;
        next_cycle();
        idle();
        @(negedge clk);
        n_total++; if (o1 !== 6'b000000) $display("FAIL idle_lat1: got %b expected %b", o1, 6'b000000); else n_pass++;
        n_total++; if (o3 !== 6'b000000) $display("FAIL idle_lat3: got %b expected %b", o3, 6'b000000); else n_pass++;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [5:0] e [3] = '{6'b110100, 6'b000000, 6'b000000};
        for (int c = 0; c < 3; c++) begin
            idle();
            if (c == 0) begin memread = 1'b1; rd = 5'd5; rs2 = 5'd5; end
            if (c == 2) begin memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; end
            @(negedge clk);
            n_total++; if (o1 !== e[c]) $display("FAIL load_use_lat1 c%0d: got %b expected %b", c, o1, e[c]); else n_pass++;
            n_total++; if (o3 !== e[c]) $display("FAIL load_use_lat3 c%0d: got %b expected %b", c, o3, e[c]); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_branch();
        idle();
        br = 1'b1;
        @(negedge clk);
        n_total++; if (o1 !== 6'b001100) $display("FAIL branch_lat1: got %b expected %b", o1, 6'b001100); else n_pass++;
        n_total++; if (o3 !== 6'b001100) $display("FAIL branch_lat3: got %b expected %b", o3, 6'b001100); else n_pass++;
        next_cycle();
        idle();
    endtask

    task automatic test_mem_access(input logic with_branch);
        logic [5:0] e3 [4];
        logic [5:0] e1 [4];
        if (with_branch) begin
            e3 = '{6'b110011, 6'b110011, 6'b001101, 6'b000000};
            e1 = '{6'b001101, 6'b001101, 6'b001101, 6'b000000};
        end else begin
            e3 = '{6'b110011, 6'b110011, 6'b101001, 6'b000000};
            e1 = '{6'b101001, 6'b101001, 6'b101001, 6'b000000};
        end
        for (int c = 0; c < 4; c++) begin
            idle();
            memop = (c < 3);
            br    = with_branch && (c < 3);
            @(negedge clk);
            n_total++; if (o3 !== e3[c]) $display("FAIL access_lat3 br=%0b c%0d: got %b expected %b", with_branch, c, o3, e3[c]); else n_pass++;
            n_total++; if (o1 !== e1[c]) $display("FAIL access_lat1 br=%0b c%0d: got %b expected %b", with_branch, c, o1, e1[c]); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_access();
        logic [5:0] e3 [6] = '{6'b110011, 6'b000000, 6'b110011, 6'b110011, 6'b101001, 6'b000000};
        logic [5:0] e1 [6] = '{6'b101001, 6'b000000, 6'b101001, 6'b101001, 6'b101001, 6'b000000};
        for (int c = 0; c < 6; c++) begin
            idle();
            memop = (c < 5);
            rst   = (c == 1);
            @(negedge clk);
            n_total++; if (o3 !== e3[c]) $display("FAIL reset_mid_lat3 c%0d: got %b expected %b", c, o3, e3[c]); else n_pass++;
            n_total++; if (o1 !== e1[c]) $display("FAIL reset_mid_lat1 c%0d: got %b expected %b", c, o1, e1[c]); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [5:0] e1, e3;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 39) == 0);
            memread = 1'($urandom_range(0, 1));
            rd      = 5'($urandom_range(0, 3));
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            memop   = ($urandom_range(0, 2) == 0);
            br      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e1 = model_out(1, left1);
            e3 = model_out(3, left3);
            n_total++; if (o1 !== e1) $display("FAIL random_lat1 c%0d: got %b expected %b", c, o1, e1); else n_pass++;
            n_total++; if (o3 !== e3) $display("FAIL random_lat3 c%0d: got %b expected %b", c, o3, e3); else n_pass++;
            n_total++; if (o3[4] && o3[3]) $display("FAIL stall_flush_exclusive c%0d: got %b expected not both", c, o3[4:3]); else n_pass++;
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        idle(); rst = 1'b1;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            idle();
            if (c == 0 || c == 2) begin memread = 1'b1; rd = 5'd5; rs1 = 5'd5; end
            if (c >= 4 && c <= 6) memop = 1'b1;
            if (c == 8) br = 1'b1;
            next_cycle();
        end
        idle();
        @(negedge clk);
        n_total++; if (lu3 !== 8'd2) $display("FAIL perf_lu_lat3: got %0d expected 2", lu3); else n_pass++;
        n_total++; if (dm3 !== 8'd3) $display("FAIL perf_dmem_lat3: got %0d expected 3", dm3); else n_pass++;
        n_total++; if (fl3 !== 8'd1) $display("FAIL perf_flush_lat3: got %0d expected 1", fl3); else n_pass++;
        n_total++; if (lu1 !== 8'd2) $display("FAIL perf_lu_lat1: got %0d expected 2", lu1); else n_pass++;
        n_total++; if (dm1 !== 8'd3) $display("FAIL perf_dmem_lat1: got %0d expected 3", dm1); else n_pass++;
        n_total++; if (fl1 !== 8'd1) $display("FAIL perf_flush_lat1: got %0d expected 1", fl1); else n_pass++;
        next_cycle();
        sat_inc = 1'b1;
        for (int c = 0; c < 5; c++) next_cycle();
        sat_inc = 1'b0;
        @(negedge clk);
        n_total++; if (sat_lu !== 2'b11) $display("FAIL perf_saturate_lu: got %b expected 11", sat_lu); else n_pass++;
        n_total++; if (sat_dm !== 2'b11) $display("FAIL perf_saturate_dmem: got %b expected 11", sat_dm); else n_pass++;
        n_total++; if (sat_fl !== 2'b11) $display("FAIL perf_saturate_flush: got %b expected 11", sat_fl); else n_pass++;
        next_cycle();
    endtask
`endif

    initial begin
        idle();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_access(1'b0);
        test_mem_access(1'b1);
        test_reset_mid_access();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
